pc_call_stack: RTL and testbench

PC_CALL_STACK -- requirements
Module: pc_call_stack

---
 rtl/pc_call_stack.sv | 72 +++++++
 tb/tb_pc_call_stack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with a LIFO return-address stack for CALL/RET.
module pc_call_stack #(
    parameter int A_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [A_WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic [2:0]               ctrl,
    input  logic [A_WIDTH-1:0]       ld_in,
    output logic [A_WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = IW + 1;
    logic [A_WIDTH-1:0] stk [DEPTH];
    logic [A_WIDTH-1:0] out_n, rel, inc;
    logic [SW-1:0] sp_n;
    logic push, ovf_n, unf_n;
    assign full = sp == SW'(DEPTH);
    assign empty = sp == '0;
    assign rel = out + ld_in;
    assign inc = out + A_WIDTH'(1);
    always_comb begin
        out_n = out;
        sp_n = sp;
        push = 1'b0;
        ovf_n = ovf;
        unf_n = unf;
        if (en) begin
            case (ctrl)
                3'b001: out_n = rel;
                3'b010: out_n = inc;
                3'b011: out_n = ld_in;
                3'b100, 3'b110: begin
                    out_n = ctrl[1] ? rel : ld_in;
                    push = !full;
                    sp_n = full ? sp : sp + SW'(1);
                    ovf_n = ovf | full;
                end
                3'b101: begin
                    out_n = empty ? out : stk[IW'(sp - SW'(1))];
                    sp_n = empty ? sp : sp - SW'(1);
                    unf_n = unf | empty;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            out <= RESET_VEC;
            sp <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            out <= out_n;
            sp <= sp_n;
            ovf <= ovf_n;
            unf <= unf_n;
        end
    end
    // Return address is the PC after the call site; storage is never reset.
    always_ff @(posedge clk) begin
        if (push && !clr) stk[sp[IW-1:0]] <= inc;
    end
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed vectors, hand sequences and random ops against a queue-based PC model.
module tb_pc_call_stack;
    logic clk = 1'b0;
    logic clr, en;
    logic [2:0] ctrl;
    logic [7:0] ld_in, out;
    logic [2:0] sp;
    logic full, empty, ovf, unf;
    int checks = 0;
    int errors = 0;

    logic [7:0] m_out;
    logic [7:0] m_stk[$];
    logic m_ovf, m_unf;

    typedef struct {
        logic c;
        logic e;
        logic [2:0] ct;
        logic [7:0] ld;
        logic [7:0] eo;
        logic [2:0] esp;
        logic eovf;
        logic eunf;
    } vec_t;
    vec_t tv[10];

    pc_call_stack #(.A_WIDTH(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .clr(clr), .en(en), .ctrl(ctrl), .ld_in(ld_in),
        .out(out), .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model out", 32'(out), 32'(m_out));
        chk("model sp", 32'(sp), 32'(m_stk.size()));
        chk("model full", 32'(full), 32'(m_stk.size() == 4));
        chk("model empty", 32'(empty), 32'(m_stk.size() == 0));
        chk("model ovf", 32'(ovf), 32'(m_ovf));
        chk("model unf", 32'(unf), 32'(m_unf));
    endtask

    task automatic apply(input logic c, input logic e, input logic [2:0] ct, input logic [7:0] ld);
        logic [7:0] tgt;
        @(negedge clk);
        clr = c; en = e; ctrl = ct; ld_in = ld;
        if (c) begin
            m_out = 8'h00; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (e) begin
            case (ct)
                3'd1: m_out = m_out + ld;
                3'd2: m_out = m_out + 8'd1;
                3'd3: m_out = ld;
                3'd4, 3'd6: begin
                    tgt = (ct == 3'd6) ? m_out + ld : ld;
                    if (m_stk.size() < 4) m_stk.push_back(m_out + 8'd1);
                    else m_ovf = 1'b1;
                    m_out = tgt;
                end
                3'd5: begin
                    if (m_stk.size() > 0) m_out = m_stk.pop_back();
                    else m_unf = 1'b1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; ctrl = 3'd0; ld_in = 8'h00;
        m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        apply(1, 0, 3'd0, 8'h00);
        chk("reset out", 32'(out), 32'h00);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);

        repeat (3) apply(0, 1, 3'd2, 8'h00);
        chk("inc3 out", 32'(out), 32'h03);
        chk("inc3 sp", 32'(sp), 32'd0);

        apply(0, 1, 3'd3, 8'h10);
        apply(0, 1, 3'd4, 8'h40);
        chk("call out", 32'(out), 32'h40);
        chk("call sp", 32'(sp), 32'd1);
        apply(0, 1, 3'd2, 8'h00);
        chk("inc out", 32'(out), 32'h41);
        chk("inc sp", 32'(sp), 32'd1);
        apply(0, 1, 3'd5, 8'h00);
        chk("ret out", 32'(out), 32'h11);
        chk("ret sp", 32'(sp), 32'd0);

        tv[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 3'd4, 8'h10, 8'h10, 3'd1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 3'd4, 8'h20, 8'h20, 3'd2, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b1, 3'd4, 8'h30, 8'h30, 3'd3, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b1, 3'd4, 8'h40, 8'h40, 3'd4, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 3'd4, 8'h50, 8'h50, 3'd4, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h31, 3'd3, 1'b1, 1'b0};
        tv[7] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h21, 3'd2, 1'b1, 1'b0};
        tv[8] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h11, 3'd1, 1'b1, 1'b0};
        tv[9] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            apply(tv[i].c, tv[i].e, tv[i].ct, tv[i].ld);
            chk($sformatf("vec%0d out", i), 32'(out), 32'(tv[i].eo));
            chk($sformatf("vec%0d sp", i), 32'(sp), 32'(tv[i].esp));
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(tv[i].eovf));
            chk($sformatf("vec%0d unf", i), 32'(unf), 32'(tv[i].eunf));
        end
        chk("full at 4", 32'(full), 32'd0);
        apply(0, 1, 3'd5, 8'h00);
        chk("underflow out", 32'(out), 32'h01);
        chk("underflow unf", 32'(unf), 32'd1);
        chk("underflow empty", 32'(empty), 32'd1);

        apply(0, 0, 3'd4, 8'h77);
        apply(0, 0, 3'd4, 8'h77);
        chk("en0 out", 32'(out), 32'h01);
        chk("en0 sp", 32'(sp), 32'd0);
        chk("en0 ovf", 32'(ovf), 32'd1);
        apply(1, 1, 3'd4, 8'h77);
        chk("clr out", 32'(out), 32'h00);
        chk("clr sp", 32'(sp), 32'd0);
        chk("clr ovf", 32'(ovf), 32'd0);
        chk("clr unf", 32'(unf), 32'd0);

        apply(0, 1, 3'd3, 8'hFE);
        apply(0, 1, 3'd2, 8'h00);
        chk("wrap ff", 32'(out), 32'hFF);
        apply(0, 1, 3'd2, 8'h00);
        chk("wrap 00", 32'(out), 32'h00);
        apply(0, 1, 3'd1, 8'hFD);
        chk("rel neg", 32'(out), 32'hFD);
        apply(0, 1, 3'd1, 8'h05);
        chk("rel pos wrap", 32'(out), 32'h02);

        apply(0, 1, 3'd3, 8'h20);
        apply(0, 1, 3'd6, 8'hF0);
        chk("call_rel out", 32'(out), 32'h10);
        chk("call_rel sp", 32'(sp), 32'd1);
        apply(0, 1, 3'd5, 8'h00);
        chk("call_rel ret", 32'(out), 32'h21);

        apply(0, 1, 3'd3, 8'h80);
        apply(0, 1, 3'd4, 8'h90);
        apply(0, 1, 3'd5, 8'h00);
        chk("b2b ret", 32'(out), 32'h81);
        apply(0, 1, 3'd4, 8'hA0);
        apply(0, 1, 3'd4, 8'hB0);
        apply(1, 1, 3'd4, 8'hC0);
        chk("clr mid sp", 32'(sp), 32'd0);
        apply(0, 1, 3'd7, 8'h55);
        chk("ctrl7 hold", 32'(out), 32'h00);
        apply(0, 1, 3'd5, 8'h00);
        chk("clr mid unf", 32'(unf), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                  3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
